mlp_wload_ctrl: RTL and testbench

MLP_WLOAD_CTRL -- requirements
Module: mlp_wload_ctrl

---
 rtl/mlp_wload_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mlp_wload_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_wload_ctrl.sv
// Weight-load sequencer: raises the MLP set[1] load flag, streams weights onto the
// slot/address weight bus, drains the pipeline, then clears the flag again.
module mlp_wload_ctrl #(
    parameter int unsigned N0 = 24,
    parameter int unsigned N1 = 48,
    parameter int unsigned N2 = 48,
    parameter int unsigned N3 = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        s_w_tvalid,
    output logic        s_w_tready,
    input  logic [15:0] s_w_tdata,
    input  logic        s_w_tlast,
    output logic [31:0] w_tdata,
    output logic        set_en,
    output logic [15:0] set_in,
    input  logic [15:0] set_out,
    output logic        act_enable,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle, StSetw, StWaitw, StLoad, StFlush, StClear, StDone
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [1:0]  r_slot;
    logic [6:0]  r_addr;
    logic [1:0]  r_flush_cnt;

    logic        w_accept;
    logic        w_start_ok;
    logic        w_slot_end;
    logic        w_last_word;
    logic [6:0]  w_slot_max;
    logic [3:0]  w_onehot;

    logic [31:0] r_w_tdata, w_w_tdata_nxt;
    logic        r_set_en, w_set_en_nxt;
    logic [15:0] r_set_in, w_set_in_nxt;
    logic        r_done, w_done_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_act_en, w_act_en_nxt;
    logic        r_err, w_err_nxt;

    always_comb begin
        unique case (r_slot)
            2'd0:    w_slot_max = 7'(N0 - 1);
            2'd1:    w_slot_max = 7'(N1 - 1);
            2'd2:    w_slot_max = 7'(N2 - 1);
            default: w_slot_max = 7'(N3 - 1);
        endcase
    end

    assign s_w_tready  = (r_state == StLoad);
    assign w_accept    = s_w_tvalid && s_w_tready;
    assign w_start_ok  = (r_state == StIdle) && start;
    assign w_slot_end  = (r_addr == w_slot_max);
    assign w_last_word = (r_slot == 2'd3) && w_slot_end;
    assign w_onehot    = 4'b0001 << r_slot;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_nxt = StSetw;
            StSetw:  w_state_nxt = StWaitw;
            StWaitw: if (set_out[1]) w_state_nxt = StLoad;
            StLoad:  if (w_accept && (w_last_word || s_w_tlast)) w_state_nxt = StFlush;
            StFlush: if (r_flush_cnt == 2'd2) w_state_nxt = StClear;
            StClear: w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // The final word occupies the first FLUSH cycle; two all-zero bus cycles follow.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_slot      <= 2'd0;
            r_addr      <= 7'd0;
            r_flush_cnt <= 2'd0;
        end else begin
            if (w_start_ok) begin
                r_slot <= 2'd0;
                r_addr <= 7'd0;
            end else if (w_accept) begin
                if (w_slot_end) begin
                    r_addr <= 7'd0;
                    r_slot <= r_slot + 2'd1;
                end else begin
                    r_addr <= r_addr + 7'd1;
                end
            end
            r_flush_cnt <= (r_state == StFlush) ? r_flush_cnt + 2'd1 : 2'd0;
        end
    end

    // Output logic, decoded from the next state so the registered outputs track the state
    always_comb begin
        w_w_tdata_nxt = w_accept ? {4'h0, w_onehot, 1'b0, r_addr, s_w_tdata} : 32'h0;
        w_set_en_nxt  = (w_state_nxt == StSetw) || (w_state_nxt == StClear);
        w_set_in_nxt  = set_out;
        if (w_state_nxt == StSetw) begin
            w_set_in_nxt[1] = 1'b1;
        end else if (w_state_nxt == StClear) begin
            w_set_in_nxt[1] = 1'b0;
        end
        w_done_nxt    = (w_state_nxt == StDone);
        w_busy_nxt    = (w_state_nxt != StIdle);
        w_act_en_nxt  = (w_state_nxt == StIdle);
        w_err_nxt     = r_err;
        if (w_start_ok) begin
            w_err_nxt = 1'b0;
        end else if (w_accept && (s_w_tlast != w_last_word)) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_w_tdata <= 32'h0;
            r_set_en  <= 1'b0;
            r_set_in  <= 16'h0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_act_en  <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_w_tdata <= w_w_tdata_nxt;
            r_set_en  <= w_set_en_nxt;
            r_set_in  <= w_set_in_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
            r_act_en  <= w_act_en_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign w_tdata    = r_w_tdata;
    assign set_en     = r_set_en;
    assign set_in     = r_set_in;
    assign done       = r_done;
    assign busy       = r_busy;
    assign act_enable = r_act_en;
    assign err        = r_err;

endmodule

// File: tb/tb_mlp_wload_ctrl.sv
// Scoreboard bench for mlp_wload_ctrl: stimulus queues expected bus words and set
// register writes; a negedge monitor pops and compares whatever the DUT presents.
module tb_mlp_wload_ctrl;

    localparam int unsigned N0 = 24;
    localparam int unsigned N1 = 48;
    localparam int unsigned N2 = 48;
    localparam int unsigned N3 = 8;
    localparam int TOTAL = N0 + N1 + N2 + N3;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        s_w_tvalid;
    logic        s_w_tready;
    logic [15:0] s_w_tdata;
    logic        s_w_tlast;
    logic [31:0] w_tdata;
    logic        set_en;
    logic [15:0] set_in;
    logic [15:0] set_out;
    logic        act_enable;
    logic        busy;
    logic        done;
    logic        err;

    mlp_wload_ctrl #(
        .N0(N0), .N1(N1), .N2(N2), .N3(N3)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .s_w_tvalid (s_w_tvalid),
        .s_w_tready (s_w_tready),
        .s_w_tdata  (s_w_tdata),
        .s_w_tlast  (s_w_tlast),
        .w_tdata    (w_tdata),
        .set_en     (set_en),
        .set_in     (set_in),
        .set_out    (set_out),
        .act_enable (act_enable),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Behavioural MLP set register
    logic        preset_we;
    logic [15:0] preset_val;
    logic [15:0] mlp_set;
    initial mlp_set = 16'h0;
    always @(posedge aclk) begin
        if (preset_we) mlp_set <= preset_val;
        else if (set_en) mlp_set <= set_in;
    end
    assign set_out = mlp_set;

    int checks   = 0;
    int failures = 0;
    logic [31:0] q_word[$];
    logic [15:0] q_set[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slot_size(input int s);
        case (s)
            0:       return N0;
            1:       return N1;
            2:       return N2;
            default: return N3;
        endcase
    endfunction

    // Word idx (0-based) of the full load -> expected bus word
    function automatic logic [31:0] exp_word(input int idx, input logic [15:0] d);
        int s;
        int rem;
        s = 0;
        rem = idx;
        while (s < 3 && rem >= slot_size(s)) begin
            rem -= slot_size(s);
            s++;
        end
        return (32'd1 << (24 + s)) | (32'(rem) << 16) | {16'h0, d};
    endfunction

    always @(negedge aclk) begin
        if (aresetn) begin
            if (w_tdata != 32'h0) begin
                if (q_word.size() == 0) check("unexpected_word", w_tdata, 32'h0);
                else check("word", w_tdata, q_word.pop_front());
            end
            if (set_en) begin
                if (q_set.size() == 0) check("unexpected_set_en", 32'(set_en), 32'h0);
                else check("set_in", 32'(set_in), 32'(q_set.pop_front()));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_w_tdata"}, w_tdata, 32'h0);
        check({tag, "_set_en"}, 32'(set_en), 32'h0);
        check({tag, "_set_in"}, 32'(set_in), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_act_enable"}, 32'(act_enable), 32'h1);
        check({tag, "_tready"}, 32'(s_w_tready), 32'h0);
    endtask

    // stop_at: index of the word carrying tlast (0 = never); gap: percent idle cycles;
    // abort_at: word index at which reset is pulsed instead of streaming on (0 = none)
    task automatic do_load(input int stop_at, input int gap, input logic [15:0] preset,
                           input bit start_busy, input int abort_at);
        int  n_words;
        int  waits;
        int  zeros;
        bit  accepted;
        bit  seen;
        logic exp_err;
        n_words = (stop_at >= 1 && stop_at <= TOTAL) ? stop_at : TOTAL;
        exp_err = (stop_at != TOTAL);
        @(negedge aclk);
        preset_we  = 1'b1;
        preset_val = preset;
        @(negedge aclk);
        preset_we  = 1'b0;
        q_set.push_back(preset | 16'h0002);
        q_set.push_back(preset & ~16'h0002);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check("setw_cycle1", 32'(set_en), 32'h1);
        check("err_cleared_on_start", 32'(err), 32'h0);
        check("busy_in_load", 32'(busy), 32'h1);
        check("act_enable_in_load", 32'(act_enable), 32'h0);
        for (int k = 1; k <= n_words; k++) begin
            accepted = 1'b0;
            waits = 0;
            while (!accepted) begin
                if (k == abort_at) begin
                    #2 aresetn = 1'b0;
                    #1 check_reset_outputs("mid_load_reset");
                    q_word.delete();
                    q_set.delete();
                    s_w_tvalid = 1'b0;
                    start = 1'b0;
                    repeat (2) @(negedge aclk);
                    aresetn = 1'b1;
                    return;
                end
                s_w_tvalid = (gap == 0) ? 1'b1 : ($urandom_range(99) >= gap);
                s_w_tdata  = 16'($urandom);
                s_w_tlast  = (k == stop_at);
                start      = start_busy && (k == 10);
                #3;
                if (s_w_tvalid && s_w_tready) begin
                    q_word.push_back(exp_word(k - 1, s_w_tdata));
                    accepted = 1'b1;
                end
                @(negedge aclk);
                waits++;
                if (waits > 200) begin
                    check("accept_timeout", 32'(k), 32'h0);
                    return;
                end
            end
        end
        start     = 1'b0;
        s_w_tlast = 1'b0;
        s_w_tvalid = (stop_at == 0);
        #3 check("tready_after_final", 32'(s_w_tready), 32'h0);
        zeros = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            if (set_en) seen = 1'b1;
            else if (w_tdata == 32'h0) zeros++;
        end
        s_w_tvalid = 1'b0;
        check("clear_seen", 32'(seen), 32'h1);
        check("flush_zero_cycles", 32'(zeros), 32'd2);
        @(negedge aclk);
        check("done_pulse", 32'(done), 32'h1);
        check("err_at_done", 32'(err), 32'(exp_err));
        @(negedge aclk);
        check("done_single", 32'(done), 32'h0);
        check("busy_idle", 32'(busy), 32'h0);
        check("act_enable_idle", 32'(act_enable), 32'h1);
        check("err_held", 32'(err), 32'(exp_err));
        check("words_drained", 32'(q_word.size()), 32'h0);
        check("sets_drained", 32'(q_set.size()), 32'h0);
        check("set_flag_cleared", 32'(set_out[1]), 32'h0);
        @(negedge aclk);
        check("set_in_follows_set_out", 32'(set_in), 32'(set_out));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn    = 1'b0;
        start      = 1'b0;
        s_w_tvalid = 1'b0;
        s_w_tdata  = 16'h0;
        s_w_tlast  = 1'b0;
        preset_we  = 1'b0;
        preset_val = 16'h0;
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle_tready", 32'(s_w_tready), 32'h0);

        do_load(TOTAL, 0, 16'h0005, 1'b0, 0);                   // normal, RMW of 0x0005
        do_load(TOTAL, 50, 16'($urandom), 1'b1, 0);             // backpressure, start ignored
        do_load(30, 30, 16'($urandom), 1'b0, 0);                // early tlast on word 30
        do_load(0, 20, 16'($urandom), 1'b0, 0);                 // tlast missing
        do_load(TOTAL, 0, 16'h0005, 1'b0, 40);                  // reset mid-load
        do_load(TOTAL, 25, 16'($urandom), 1'b0, 0);             // restart from slot 0

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
